multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
- Parametrised N-channel edge detector with input synchroniser, optional glitch filter and per-channel mode (rise/fall/both/off).
- Each enabled edge produces a one-cycle pulse plus a sticky status flag, cleared by a per-channel clear.
- A single interrupt line is driven from the sticky flags.
- Sits between asynchronous external/cross-domain level signals and control logic that needs edge events.

Parameters:
- NUM_CH, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, flops in the input synchroniser chain (>=2)
- FILTER_CYCLES, 0, consecutive stable cycles required before the filtered level changes; 0 = filter bypassed (0..255)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- sig_in  input  NUM_CH  raw asynchronous level inputs
- mode  input  2*NUM_CH  per-channel edge_mode_e, channel i at [2i+1:2i]
- clr  input  NUM_CH  per-channel sticky clear, synchronous, level-sampled
- sig_filt  output  NUM_CH  synchronised and filtered level
- edge_pulse  output  NUM_CH  one-cycle pulse per detected enabled edge
- edge_rise  output  NUM_CH  qualifies edge_pulse: 1 = rising, 0 = falling; valid only while edge_pulse=1, 0 otherwise
- sticky  output  NUM_CH  latched event flags
- irq  output  1  OR of all sticky bits

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst).
  - Assertion immediately clears all sync flops, filter counters, filtered levels, previous-level flops and outputs (sig_filt, edge_pulse, edge_rise, sticky, irq = 0).
  - Reset mid-operation discards pending filter counts and sticky events.
- Synchroniser: sig_in passes through SYNC_STAGES flops per channel. No combinational path from sig_in to any output.
- Filter (FILTER_CYCLES>0):
  - Per-channel counter of width clog2(FILTER_CYCLES+1).
  - While the synced level differs from sig_filt, the counter increments. When it reaches FILTER_CYCLES, sig_filt takes the synced level and the counter returns to 0.
  - Whenever the synced level equals sig_filt, the counter is cleared.
  - Pulses shorter than FILTER_CYCLES cycles (post-sync) are fully suppressed.
- Filter bypass (FILTER_CYCLES=0): sig_filt equals the last sync stage.
- Edge detect: a registered previous copy of sig_filt.
  - Rise = sig_filt & ~prev; fall = ~sig_filt & prev.
  - edge_pulse and edge_rise are registered, so the pulse occupies the cycle after sig_filt changes.
- Latency: if sig_in holds a new level at clock edge k (first sampling edge), edge_pulse is high in the cycle following edge k+SYNC_STAGES+FILTER_CYCLES. It stays high for exactly one cycle.
- Mode gating, using the mode value sampled on the same edge that registers the pulse:
  - OFF (00): no pulse, no sticky set.
  - RISE (01): rising edges only.
  - FALL (10): falling edges only.
  - BOTH (11): both edges.
- A mode change alone never generates an edge. sig_filt keeps tracking regardless of mode.
- Sticky:
  - Set on the edge that registers edge_pulse=1.
  - Cleared on an edge where clr=1 and no new event occurs.
  - Simultaneous set and clr: set wins.
- irq = |sticky, driven directly from flops (glitch-free).
- Reset release with sig_in high: the level history starts at 0, so a rising edge is reported after the normal latency.
- Back-to-back edges: minimum spacing is 1 + FILTER_CYCLES cycles. Every filtered transition produces its own pulse, with no merging.

Decomposition:
- Package edge_det_pkg:
  - typedef enum logic [1:0] edge_mode_e {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
  - Function for counter width.
- Sub-module edge_det_channel: sync chain, filter, prev flop, mode gating, sticky for one channel.
- Top multi_edge_detector generates NUM_CH instances and ORs sticky into irq.

Test Plan:
- Reset while sig_in=4'hF and all modes BOTH -> all outputs 0 during reset; after release each channel pulses rising once at cycle SYNC_STAGES+FILTER_CYCLES; sticky=4'hF; irq=1.
- FILTER_CYCLES=3, ch0 RISE, 2-cycle high glitch -> no pulse, sig_filt[0] stays 0. Then a 10-cycle high -> one rising pulse at latency 5 (SYNC_STAGES=2), sticky[0]=1.
- ch1 FALL, toggle 1->0->1 with 8-cycle spacing -> exactly one pulse, edge_rise[1]=0, aligned to the falling transition only.
- ch2 BOTH, mode switched to OFF on the pulse-register edge -> no pulse, sticky[2] unchanged; switch back to BOTH with no input change -> no pulse.
- sticky[3]=1, assert clr[3] for one cycle -> sticky[3]=0 next cycle, irq=0. Repeat with clr[3] coincident with a new event -> sticky[3] remains 1.
- Assert rst mid-filter (counter=2 of 3) -> counter, sticky and outputs clear immediately. After release the stable input re-qualifies with the full FILTER_CYCLES delay.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Filter counter width; never below one bit so the bypass build still elaborates.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, optional stability filter, edge detect, mode gating, sticky flag.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  input  edge_mode_e mode,
  input  logic       clr,
  output logic       sig_filt,
  output logic       edge_pulse,
  output logic       edge_rise,
  output logic       sticky,
  output logic       sticky_nxt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  logic                   w_filt;
  logic                   r_prev;
  logic                   r_pulse;
  logic                   r_rise;
  logic                   r_sticky;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES > 0) begin : g_filt
      localparam int            CW      = cnt_width(FILTER_CYCLES);
      localparam logic [CW-1:0] LP_LAST = CW'(FILTER_CYCLES - 1);
      logic [CW-1:0] r_cnt;
      logic          r_filt;

      // The level only moves after FILTER_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (w_synced == r_filt) begin
          r_cnt  <= '0;
        end else if (r_cnt == LP_LAST) begin
          r_cnt  <= '0;
          r_filt <= w_synced;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end

      assign w_filt = r_filt;
    end else begin : g_bypass
      assign w_filt = w_synced;
    end
  endgenerate

  assign w_rise = w_filt & ~r_prev;
  assign w_fall = ~w_filt & r_prev;

  always_comb begin
    w_evt = 1'b0;
    case (mode)
      EDGE_RISE: w_evt = w_rise;
      EDGE_FALL: w_evt = w_fall;
      EDGE_BOTH: w_evt = w_rise | w_fall;
      default:   w_evt = 1'b0;
    endcase
  end

  // A new event outranks a coincident clear.
  assign sticky_nxt = w_evt | (r_sticky & ~clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev   <= 1'b0;
      r_pulse  <= 1'b0;
      r_rise   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_prev   <= w_filt;
      r_pulse  <= w_evt;
      r_rise   <= w_evt & w_rise;
      r_sticky <= sticky_nxt;
    end
  end

  assign sig_filt   = w_filt;
  assign edge_pulse = r_pulse;
  assign edge_rise  = r_rise;
  assign sticky     = r_sticky;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector with a registered interrupt formed from the sticky flags.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     sig_in,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     clr,
  output logic [NUM_CH-1:0]     sig_filt,
  output logic [NUM_CH-1:0]     edge_pulse,
  output logic [NUM_CH-1:0]     edge_rise,
  output logic [NUM_CH-1:0]     sticky,
  output logic                  irq
);

  logic [NUM_CH-1:0] w_sticky_nxt;
  logic              r_irq;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in[i]),
      .mode      (edge_mode_e'(mode[2*i +: 2])),
      .clr       (clr[i]),
      .sig_filt  (sig_filt[i]),
      .edge_pulse(edge_pulse[i]),
      .edge_rise (edge_rise[i]),
      .sticky    (sticky[i]),
      .sticky_nxt(w_sticky_nxt[i])
    );
  end

  // irq is a flop fed from the next-state sticky vector, so it tracks sticky with no lag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= |w_sticky_nxt;
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector built with SYNC_STAGES=2, FILTER_CYCLES=3.
module tb_multi_edge_detector;

  logic       clk;
  logic       rst;
  logic [3:0] sig_in;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] sig_filt;
  logic [3:0] edge_pulse;
  logic [3:0] edge_rise;
  logic [3:0] sticky;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  multi_edge_detector #(
    .NUM_CH       (4),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .mode      (mode),
    .clr       (clr),
    .sig_filt  (sig_filt),
    .edge_pulse(edge_pulse),
    .edge_rise (edge_rise),
    .sticky    (sticky),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [3:0] lvl);
    mode   = 8'h00;
    sig_in = lvl;
    repeat (10) step();
    clr = 4'hF;
    step();
    clr = 4'h0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_p;
    rst = 1'b0; sig_in = 4'hF; mode = 8'hFF; clr = 4'h0;
    repeat (3) step();
    n_tests++;
    if ({sig_filt, edge_pulse, edge_rise, sticky, irq} !== 17'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {sig_filt, edge_pulse, edge_rise, sticky, irq});
    end
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_p = (e == 6) ? 4'hF : 4'h0;
      n_tests++;
      if (edge_pulse !== exp_p) begin
        n_fail++; $display("FAIL reset_release_pulse e=%0d got %h want %h", e, edge_pulse, exp_p);
      end
      n_tests++;
      if (edge_rise !== exp_p) begin
        n_fail++; $display("FAIL reset_release_rise e=%0d got %h want %h", e, edge_rise, exp_p);
      end
      if (e == 4) begin
        n_tests++;
        if (sig_filt !== 4'h0) begin
          n_fail++; $display("FAIL reset_filt_early got %h want 0", sig_filt);
        end
      end
      if (e >= 5) begin
        n_tests++;
        if (sig_filt !== 4'hF) begin
          n_fail++; $display("FAIL reset_filt_late e=%0d got %h want f", e, sig_filt);
        end
      end
      if (e >= 6) begin
        n_tests++;
        if (sticky !== 4'hF || irq !== 1'b1) begin
          n_fail++; $display("FAIL reset_sticky e=%0d got %h/%b want f/1", e, sticky, irq);
        end
      end
    end
  endtask

  task automatic test_glitch_filter();
    logic exp_b;
    settle(4'h0);
    mode = 8'b00_00_00_01;
    for (int e = 1; e <= 12; e++) begin
      sig_in[0] = (e <= 2);
      step();
      n_tests++;
      if (edge_pulse[0] !== 1'b0 || sig_filt[0] !== 1'b0) begin
        n_fail++; $display("FAIL glitch e=%0d got pulse %b filt %b want 0 0", e, edge_pulse[0], sig_filt[0]);
      end
    end
    for (int e = 1; e <= 10; e++) begin
      sig_in[0] = 1'b1;
      step();
      exp_b = (e == 6);
      n_tests++;
      if (edge_pulse[0] !== exp_b || edge_rise[0] !== exp_b) begin
        n_fail++; $display("FAIL long_pulse e=%0d got %b/%b want %b", e, edge_pulse[0], edge_rise[0], exp_b);
      end
      if (e == 6) begin
        n_tests++;
        if (sticky[0] !== 1'b1) begin
          n_fail++; $display("FAIL long_sticky got %b want 1", sticky[0]);
        end
      end
    end
  endtask

  task automatic test_fall_only();
    logic exp_b;
    mode = 8'b00_00_10_01;
    for (int seg = 0; seg < 3; seg++) begin
      for (int e = 1; e <= 8; e++) begin
        sig_in[1] = (seg != 1);
        step();
        exp_b = (seg == 1) && (e == 6);
        n_tests++;
        if (edge_pulse[1] !== exp_b || edge_rise[1] !== 1'b0) begin
          n_fail++; $display("FAIL fall seg=%0d e=%0d got %b/%b want %b/0", seg, e, edge_pulse[1], edge_rise[1], exp_b);
        end
      end
    end
  endtask

  task automatic test_mode_off();
    mode[5:4] = 2'b11;
    for (int e = 1; e <= 5; e++) begin
      sig_in[2] = 1'b1;
      step();
    end
    mode[5:4] = 2'b00;
    step();
    n_tests++;
    if (edge_pulse[2] !== 1'b0 || sticky[2] !== 1'b0 || sig_filt[2] !== 1'b1) begin
      n_fail++; $display("FAIL mode_off got pulse %b sticky %b filt %b want 0 0 1", edge_pulse[2], sticky[2], sig_filt[2]);
    end
    repeat (2) step();
    mode[5:4] = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_tests++;
      if (edge_pulse[2] !== 1'b0 || sticky[2] !== 1'b0) begin
        n_fail++; $display("FAIL mode_back e=%0d got %b/%b want 0/0", e, edge_pulse[2], sticky[2]);
      end
    end
  endtask

  task automatic test_sticky_clear();
    clr = 4'hF;
    step();
    clr = 4'h0;
    mode[7:6] = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      sig_in[3] = 1'b1;
      step();
      if (e == 5) begin
        n_tests++;
        if (irq !== 1'b0) begin
          n_fail++; $display("FAIL irq_idle got %b want 0", irq);
        end
      end
    end
    n_tests++;
    if (edge_pulse[3] !== 1'b1 || sticky[3] !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL ch3_set got %b/%b/%b want 1/1/1", edge_pulse[3], sticky[3], irq);
    end
    clr[3] = 1'b1;
    step();
    clr = 4'h0;
    n_tests++;
    if (sticky[3] !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL ch3_clear got %b/%b want 0/0", sticky[3], irq);
    end
    for (int e = 1; e <= 6; e++) begin
      sig_in[3] = 1'b0;
      clr[3]    = (e == 6);
      step();
    end
    clr = 4'h0;
    n_tests++;
    if (edge_pulse[3] !== 1'b1 || edge_rise[3] !== 1'b0 || sticky[3] !== 1'b1) begin
      n_fail++; $display("FAIL set_beats_clr got %b/%b/%b want 1/0/1", edge_pulse[3], edge_rise[3], sticky[3]);
    end
    step();
    n_tests++;
    if (sticky[3] !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL set_beats_clr_hold got %b/%b want 1/1", sticky[3], irq);
    end
  endtask

  task automatic test_reset_mid_filter();
    logic exp_b;
    settle(4'h0);
    mode = 8'hFF;
    for (int e = 1; e <= 4; e++) begin
      sig_in = 4'h1;
      step();
      n_tests++;
      if (edge_pulse !== 4'h0) begin
        n_fail++; $display("FAIL prefilter e=%0d got %h want 0", e, edge_pulse);
      end
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({sig_filt, edge_pulse, edge_rise, sticky, irq} !== 17'b0) begin
      n_fail++; $display("FAIL async_reset got %h want 0", {sig_filt, edge_pulse, edge_rise, sticky, irq});
    end
    step();
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_b = (e == 6);
      n_tests++;
      if (edge_pulse[0] !== exp_b || sticky[0] !== (e >= 6)) begin
        n_fail++; $display("FAIL requalify e=%0d got %b/%b want %b/%b", e, edge_pulse[0], sticky[0], exp_b, (e >= 6));
      end
    end
  endtask

  initial begin
    rst = 1'b0; sig_in = 4'h0; mode = 8'h00; clr = 4'h0;
    test_reset();
    test_glitch_filter();
    test_fall_only();
    test_mode_off();
    test_sticky_clear();
    test_reset_mid_filter();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
